// File: rtl/cam_dvp_source.sv
// cam_dvp_source
//   OV7670-style DVP transmitter used as a stand-in for the physical camera.
//   It emits vsync/href/data with the camera's frame and line timing, one
//   RGB565 byte per clock (high byte first), carrying a selectable test pattern.
//
// Ports
//   i_clk          byte (pixel) clock, all logic on the rising edge
//   i_rst          synchronous active-high reset
//   i_enable       run request, sampled only at frame boundaries
//   i_mode         pattern: 0 colour bars, 1 {line,px} counter, 2/3 solid
//   i_solid        RGB565 value for the solid modes
//   o_vsync        vsync, active high
//   o_href         high during active pixel bytes
//   o_data         pixel byte
//   o_sof          one-clock pulse on the first vsync-high cycle of a frame
//   o_busy         high whenever a frame is in progress
//   o_frame_count  completed frames, wraps silently
module cam_dvp_source #(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int H_BLANK     = 144,
  parameter int VSYNC_LINES = 3,
  parameter int V_BACK      = 17,
  parameter int V_FRONT     = 10
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_enable,
  input  logic [1:0]  i_mode,
  input  logic [15:0] i_solid,
  output logic        o_vsync,
  output logic        o_href,
  output logic [7:0]  o_data,
  output logic        o_sof,
  output logic        o_busy,
  output logic [15:0] o_frame_count
);

  localparam int L        = 2 * H_ACTIVE + H_BLANK;
  localparam int HW       = $clog2(L);
  localparam int LINE_SUM = VSYNC_LINES + V_BACK + V_ACTIVE + V_FRONT;
  localparam int VW       = $clog2(LINE_SUM + 1);
  localparam int BAR_W    = H_ACTIVE / 8;

  localparam logic [HW-1:0] HCNT_LAST = HW'(L - 1);
  localparam logic [HW-1:0] HREF_END  = HW'(2 * H_ACTIVE);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_VSYNC  = 3'd1,
    ST_VBACK  = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_VFRONT = 3'd4
  } state_t;

  // Index of the last line period spent in a given state.
  function automatic logic [VW-1:0] last_line(input state_t st);
    logic [VW-1:0] r;
    case (st)
      ST_VSYNC:  r = VW'(VSYNC_LINES - 1);
      ST_VBACK:  r = VW'(V_BACK - 1);
      ST_ACTIVE: r = VW'(V_ACTIVE - 1);
      ST_VFRONT: r = VW'(V_FRONT - 1);
      default:   r = {VW{1'b0}};
    endcase
    return r;
  endfunction

  // Colour of the eight equal-width bars, left to right.
  function automatic logic [15:0] bar_color(input logic [2:0] idx);
    logic [15:0] c;
    case (idx)
      3'd0:    c = 16'hFFFF;
      3'd1:    c = 16'hFFE0;
      3'd2:    c = 16'h07FF;
      3'd3:    c = 16'h07E0;
      3'd4:    c = 16'hF81F;
      3'd5:    c = 16'hF800;
      3'd6:    c = 16'h001F;
      default: c = 16'h0000;
    endcase
    return c;
  endfunction

  state_t        state_r, state_s;
  logic [HW-1:0] hcnt_r, hcnt_s;
  logic [VW-1:0] line_r, line_s;
  logic [1:0]    mode_r, mode_s;
  logic [15:0]   solid_r, solid_s;
  logic          frame_end_s;

  logic [2:0]    bar_idx_s;
  logic [7:0]    px8_s;
  logic [7:0]    line8_s;
  logic [15:0]   pixel_s;
  logic          href_s;
  logic [7:0]    data_s;

  // Next-state and counter values; outputs are registered from these so they
  // line up with the state they describe.
  always_comb begin
    state_s     = state_r;
    hcnt_s      = hcnt_r;
    line_s      = line_r;
    mode_s      = mode_r;
    solid_s     = solid_r;
    frame_end_s = 1'b0;
    if (state_r == ST_IDLE) begin
      hcnt_s = {HW{1'b0}};
      line_s = {VW{1'b0}};
      if (i_enable) begin
        state_s = ST_VSYNC;
        mode_s  = i_mode;
        solid_s = i_solid;
      end else begin
        state_s = ST_IDLE;
      end
    end else if (hcnt_r != HCNT_LAST) begin
      hcnt_s = hcnt_r + HW'(1);
    end else if (line_r != last_line(state_r)) begin
      hcnt_s = {HW{1'b0}};
      line_s = line_r + VW'(1);
    end else begin
      hcnt_s = {HW{1'b0}};
      line_s = {VW{1'b0}};
      case (state_r)
        ST_VSYNC:  state_s = ST_VBACK;
        ST_VBACK:  state_s = ST_ACTIVE;
        ST_ACTIVE: state_s = ST_VFRONT;
        ST_VFRONT: begin
          frame_end_s = 1'b1;
          // Back-to-back frames relatch the pattern here, never mid-frame.
          if (i_enable) begin
            state_s = ST_VSYNC;
            mode_s  = i_mode;
            solid_s = i_solid;
          end else begin
            state_s = ST_IDLE;
          end
        end
        default:   state_s = ST_IDLE;
      endcase
    end
  end

  // Pixel value and byte selection for the upcoming cycle.
  always_comb begin
    bar_idx_s = 3'((32'(hcnt_s) >> 1) / 32'(BAR_W));
    px8_s     = 8'(hcnt_s >> 1);
    line8_s   = 8'(line_s);
    case (mode_s)
      2'd0:    pixel_s = bar_color(bar_idx_s);
      2'd1:    pixel_s = {line8_s, px8_s};
      default: pixel_s = solid_r == solid_s ? solid_s : solid_s;
    endcase
    href_s = (state_s == ST_ACTIVE) && (hcnt_s < HREF_END);
    if (!href_s) begin
      data_s = 8'h00;
    end else if (hcnt_s[0]) begin
      data_s = pixel_s[7:0];
    end else begin
      data_s = pixel_s[15:8];
    end
  end

  // State, counters, latched pattern and all registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r       <= ST_IDLE;
      hcnt_r        <= {HW{1'b0}};
      line_r        <= {VW{1'b0}};
      mode_r        <= 2'd0;
      solid_r       <= 16'h0000;
      o_vsync       <= 1'b0;
      o_href        <= 1'b0;
      o_data        <= 8'h00;
      o_sof         <= 1'b0;
      o_busy        <= 1'b0;
      o_frame_count <= 16'h0000;
    end else begin
      state_r       <= state_s;
      hcnt_r        <= hcnt_s;
      line_r        <= line_s;
      mode_r        <= mode_s;
      solid_r       <= solid_s;
      o_vsync       <= (state_s == ST_VSYNC);
      o_href        <= href_s;
      o_data        <= data_s;
      o_sof         <= (state_s == ST_VSYNC) && (state_r != ST_VSYNC);
      o_busy        <= (state_s != ST_IDLE);
      o_frame_count <= frame_end_s ? o_frame_count + 16'd1 : o_frame_count;
    end
  end

endmodule

// File: doc/cam_dvp_source.md
Name: cam_dvp_source

Overview:
- Synthesizable OV7670-style DVP transmitter. It produces vsync, href and 8-bit RGB565 byte streams with the camera's frame and line timing.
- Bring-up and simulation stand-in for the physical camera. It drives the capture path (pixel-clock-domain vsync/href/data inputs) with known test patterns, so the capture → Gaussian filter → framebuffer → display chain can be checked without a sensor.
- Single clock domain; one output byte per clock.

Parameters:
- H_ACTIVE, 640, active pixels per line (2 bytes each); multiple of 8.
- V_ACTIVE, 480, active lines per frame.
- H_BLANK, 144, href-low clocks after each active line.
- VSYNC_LINES, 3, line periods with vsync high.
- V_BACK, 17, line periods after vsync before the first active line.
- V_FRONT, 10, line periods after the last active line.

Ports:
- i_clk  in  1  byte clock (pixel clock); all logic rising-edge.
- i_rst  in  1  synchronous active-high reset.
- i_enable  in  1  run request, sampled at frame boundaries.
- i_mode  in  2  pattern select: 0 color bars, 1 coordinate counter, 2 solid, 3 solid.
- i_solid  in  16  RGB565 value used in solid mode.
- o_vsync  out  1  DVP vsync, active high.
- o_href  out  1  DVP href, high during active bytes.
- o_data  out  8  DVP data byte.
- o_sof  out  1  one-clock pulse on the first vsync-high cycle.
- o_busy  out  1  high whenever not IDLE.
- o_frame_count  out  16  frames completed, wraps at 0xFFFF→0.

Behaviour:
- All outputs registered.
- Reset values: o_vsync=0, o_href=0, o_data=0, o_sof=0, o_busy=0, o_frame_count=0; state=IDLE; all counters 0.
- Line period L = 2*H_ACTIVE + H_BLANK clocks. Column counter hcnt runs 0..L-1 in every non-IDLE state.
- States:
  - IDLE: if i_enable=1, latch i_mode and i_solid, then go to VSYNC. The cycle after i_enable is sampled high shows o_vsync=1 and o_sof=1.
  - VSYNC: o_vsync=1 for VSYNC_LINES*L clocks, then go to VBACK.
  - VBACK: all outputs low for V_BACK*L clocks, then go to ACTIVE with line=0.
  - ACTIVE:
    - hcnt < 2*H_ACTIVE: o_href=1 and o_data carries the pixel bytes.
    - otherwise: o_href=0 and o_data=0.
    - At hcnt=L-1: line increments. After line V_ACTIVE-1, go to VFRONT.
  - VFRONT: outputs low for V_FRONT*L clocks. On its last clock o_frame_count increments, then:
    - i_enable=1: go to VSYNC and relatch mode/solid.
    - i_enable=0: go to IDLE.
- Deasserting i_enable mid-frame never truncates the frame; the current frame always completes.
- Pixel index px = hcnt>>1.
  - Even hcnt sends pixel[15:8]; odd hcnt sends pixel[7:0].
  - Inside a pixel the high byte always precedes the low byte.
- Pixel value by mode:
  - Mode 0: 8 equal bars of width H_ACTIVE/8, left to right: FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
  - Mode 1: {line[7:0], px[7:0]}.
  - Modes 2 and 3: the latched i_solid.
- Mode and solid-value changes mid-frame are ignored until the next frame start.
- o_busy=1 in VSYNC, VBACK, ACTIVE and VFRONT.
- i_rst mid-frame: the next cycle shows all reset values and the state is IDLE; no partial-frame count is recorded.
- o_frame_count wraps silently.

Test Plan:
(Bench uses H_ACTIVE=8, V_ACTIVE=4, H_BLANK=4, VSYNC_LINES=1, V_BACK=1, V_FRONT=1, so L=20 and a frame is 140 clocks.)
- Reset, i_enable=0 for 50 clocks → all outputs 0, o_busy=0.
- i_enable=1, mode 0 held → o_sof at cycle 1 and 141, then every 140 clocks. o_vsync high for 20 clocks. Exactly 4 href pulses of 16 clocks per frame. Line 0 bytes are FF,FF,FF,E0,07,FF,07,E0,F8,1F,F8,00,00,1F,00,00.
- Mode 1 → line 2 bytes are 02,00,02,01,…,02,07. Three frames complete → o_frame_count=3.
- Mode 2, i_solid=0x1234, then change to mode 0 in the middle of line 1 → rest of that frame stays 12,34 repeated; the next frame shows color bars.
- i_enable dropped during line 1 → frame finishes, o_frame_count increments once, state returns to IDLE, o_busy=0, and no further o_sof.
- i_rst asserted at an ACTIVE byte → next cycle o_href=0, o_data=0, o_frame_count=0. Re-enable → a clean frame begins with o_sof.
